// File: rtl/tag_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tag_bank_pkg
// Description : Shared types, default sizes and a priority-encode helper for
//               the N-way tag bank.
//               - tb_state_t : flush sequencer states
//               - DEF_*      : default WAYS / SETS / TAG_W
//               - lowest_set : index of the lowest set bit (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
package tag_bank_pkg;

  localparam int DEF_WAYS  = 4;
  localparam int DEF_SETS  = 64;
  localparam int DEF_TAG_W = 20;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } tb_state_t;

  // Priority encoder shared by first-hit and first-invalid selection.
  // Scanning from the top down leaves the lowest set index as the result.
  function automatic int unsigned lowest_set(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/way_mux_nto1.sv
`default_nettype none
// ============================================================================
// Module      : way_mux_nto1
// Description : Combinational N:1 mux selecting one W-bit entry of a row.
//               Ports: din  - N packed entries of W bits
//                      sel  - entry index
//                      dout - selected entry
// Revision    : 1.0 - initial release
// ============================================================================
module way_mux_nto1 #(
  parameter int N = 4,
  parameter int W = 20
) (
  input  logic [N-1:0][W-1:0]     din,
  input  logic [$clog2(N)-1:0]    sel,
  output logic [W-1:0]            dout
);

  assign dout = din[sel];

endmodule
`default_nettype wire

// File: rtl/tag_bank_nway.sv
`default_nettype none
// ============================================================================
// Module      : tag_bank_nway
// Description : N-way set-associative tag bank. Lookups snapshot the addressed
//               set at the request edge (so a same-edge fill is not seen) and
//               resolve hit / victim from that snapshot one cycle later.
//               Victim on miss: lowest invalid way, else the set's round-robin
//               pointer. flush_req walks every set clearing valid bits.
//               Ports:
//                 clk, rst                      - clock, sync active-high reset
//                 lk_valid/lk_index/lk_tag      - lookup request
//                 rsp_valid/hit/way/tag         - lookup response (held)
//                 fill_valid/index/way/tag      - tag write, marks way valid
//                 flush_req, busy, flush_done   - whole-bank invalidate
//               Optional macro TAG_BANK_PARITY_EN: per-entry even parity,
//               bad-parity ways never hit, adds output rsp_perr.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_bank_nway
  import tag_bank_pkg::*;
#(
  parameter int WAYS  = DEF_WAYS,
  parameter int SETS  = DEF_SETS,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lk_valid,
  input  logic [$clog2(SETS)-1:0]   lk_index,
  input  logic [TAG_W-1:0]          lk_tag,
  output logic                      rsp_valid,
  output logic                      rsp_hit,
  output logic [$clog2(WAYS)-1:0]   rsp_way,
  output logic [TAG_W-1:0]          rsp_tag,
  input  logic                      fill_valid,
  input  logic [$clog2(SETS)-1:0]   fill_index,
  input  logic [$clog2(WAYS)-1:0]   fill_way,
  input  logic [TAG_W-1:0]          fill_tag,
  input  logic                      flush_req,
  output logic                      busy,
  output logic                      flush_done
`ifdef TAG_BANK_PARITY_EN
  ,output logic                     rsp_perr
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

  // Storage (tags are not reset; valid bits gate their use)
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  valid_d [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];
  logic [WAY_W-1:0] rr_d    [SETS];

  // Flush sequencer
  tb_state_t        state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             flush_done_q, flush_done_d;

  // Registered lookup: request tag plus a snapshot of the addressed set
  logic                        rsp_valid_q, rsp_valid_d;
  logic [TAG_W-1:0]            lk_tag_q, lk_tag_d;
  logic [WAYS-1:0]             row_valid_q, row_valid_d;
  logic [WAY_W-1:0]            row_rr_q, row_rr_d;
  logic [WAYS-1:0][TAG_W-1:0]  row_tag_q, row_tag_d;

  logic lk_acc, fill_we;

  // A flush request in the same idle cycle wins over a fill.
  assign lk_acc  = lk_valid && (state_q == IDLE);
  assign fill_we = fill_valid && (state_q == IDLE) && !flush_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        if (cnt_q == LAST_SET) state_d = IDLE;
        else                   cnt_d   = cnt_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d       = (state_d == FLUSH);
    // Registered so it is high during the cycle that clears the last set.
    flush_done_d = (state_d == FLUSH) && (cnt_d == LAST_SET);
  end

  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      valid_d[s] = valid_q[s];
      rr_d[s]    = rr_q[s];
    end
    if (fill_we) begin
      valid_d[fill_index][fill_way] = 1'b1;
      rr_d[fill_index]              = fill_way + WAY_W'(1);
    end
    if (state_q == FLUSH) valid_d[cnt_q] = '0;
  end

  always_comb begin
    rsp_valid_d = lk_acc;
    lk_tag_d    = lk_tag_q;
    row_valid_d = row_valid_q;
    row_rr_d    = row_rr_q;
    row_tag_d   = row_tag_q;
    if (lk_acc) begin
      lk_tag_d    = lk_tag;
      row_valid_d = valid_q[lk_index];
      row_rr_d    = rr_q[lk_index];
      for (int w = 0; w < WAYS; w++) row_tag_d[w] = tag_q[lk_index][w];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      lk_tag_q     <= '0;
      row_valid_q  <= '0;
      row_rr_q     <= '0;
      row_tag_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      flush_done_q <= flush_done_d;
      rsp_valid_q  <= rsp_valid_d;
      lk_tag_q     <= lk_tag_d;
      row_valid_q  <= row_valid_d;
      row_rr_q     <= row_rr_d;
      row_tag_q    <= row_tag_d;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= valid_d[s];
        rr_q[s]    <= rr_d[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) tag_q[fill_index][fill_way] <= fill_tag;
  end

`ifdef TAG_BANK_PARITY_EN
  logic [WAYS-1:0] par_q [SETS];
  logic [WAYS-1:0] row_par_q, row_par_d;
  logic [WAYS-1:0] bad_par;

  always_comb begin
    row_par_d = row_par_q;
    if (lk_acc) row_par_d = par_q[lk_index];
  end

  always_ff @(posedge clk) begin
    if (rst) row_par_q <= '0;
    else     row_par_q <= row_par_d;
  end

  always_ff @(posedge clk) begin
    if (fill_we) par_q[fill_index][fill_way] <= ^fill_tag;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_par
    assign bad_par[w] = row_valid_q[w] && ((^row_tag_q[w]) != row_par_q[w]);
  end

  assign rsp_perr = rsp_valid_q && (|bad_par);
`endif

  // Hit / victim resolution from the snapshot
  logic [WAYS-1:0]  match;
  logic             hit_any;
  logic [WAY_W-1:0] hit_way, victim, sel_way;

  for (genvar w = 0; w < WAYS; w++) begin : g_match
`ifdef TAG_BANK_PARITY_EN
    assign match[w] = row_valid_q[w] && !bad_par[w] && (row_tag_q[w] == lk_tag_q);
`else
    assign match[w] = row_valid_q[w] && (row_tag_q[w] == lk_tag_q);
`endif
  end

  assign hit_any = |match;
  assign hit_way = WAY_W'(lowest_set(32'(match)));
  assign victim  = (&row_valid_q) ? row_rr_q : WAY_W'(lowest_set(32'(~row_valid_q)));
  assign sel_way = hit_any ? hit_way : victim;

  way_mux_nto1 #(
    .N (WAYS),
    .W (TAG_W)
  ) u_tag_mux (
    .din  (row_tag_q),
    .sel  (sel_way),
    .dout (rsp_tag)
  );

  assign rsp_valid  = rsp_valid_q;
  assign rsp_hit    = hit_any;
  assign rsp_way    = sel_way;
  assign busy       = busy_q;
  assign flush_done = flush_done_q;

endmodule
`default_nettype wire

// File: tb/tb_tag_bank_nway.sv
`default_nettype none
// ============================================================================
// Module      : tb_tag_bank_nway
// Description : Self-checking bench for tag_bank_nway. Lookups push expected
//               responses from a set/way array model into a queue; a monitor
//               pops and compares whenever rsp_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tag_bank_nway;

  localparam int WAYS  = 4;
  localparam int SETS  = 64;
  localparam int TAG_W = 20;
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lk_valid = 1'b0;
  logic [IDX_W-1:0] lk_index = '0;
  logic [TAG_W-1:0] lk_tag = '0;
  logic             rsp_valid, rsp_hit;
  logic [WAY_W-1:0] rsp_way;
  logic [TAG_W-1:0] rsp_tag;
  logic             fill_valid = 1'b0;
  logic [IDX_W-1:0] fill_index = '0;
  logic [WAY_W-1:0] fill_way = '0;
  logic [TAG_W-1:0] fill_tag = '0;
  logic             flush_req = 1'b0;
  logic             busy, flush_done;
`ifdef TAG_BANK_PARITY_EN
  logic             rsp_perr;
`endif

  tag_bank_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .lk_valid   (lk_valid),
    .lk_index   (lk_index),
    .lk_tag     (lk_tag),
    .rsp_valid  (rsp_valid),
    .rsp_hit    (rsp_hit),
    .rsp_way    (rsp_way),
    .rsp_tag    (rsp_tag),
    .fill_valid (fill_valid),
    .fill_index (fill_index),
    .fill_way   (fill_way),
    .fill_tag   (fill_tag),
    .flush_req  (flush_req),
    .busy       (busy),
    .flush_done (flush_done)
`ifdef TAG_BANK_PARITY_EN
    ,.rsp_perr  (rsp_perr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int cyc;
    bit hit;
    int way;
    int tag;
    bit tag_known;
  } exp_t;

  exp_t sbq[$];
  bit   mv [SETS][WAYS];
  bit   mw [SETS][WAYS];
  int   mt [SETS][WAYS];
  int   mrr[SETS];
  int   flush_left = 0;
  int   flush_pos  = 0;

  function automatic exp_t model_lookup(input int s, input int t);
    exp_t e;
    int   inv;
    e.cyc = cyc; e.hit = 0; e.way = 0;
    for (int w = 0; w < WAYS; w++)
      if (!e.hit && mv[s][w] && mt[s][w] == t) begin e.hit = 1; e.way = w; end
    if (!e.hit) begin
      inv = -1;
      for (int w = 0; w < WAYS; w++) if (inv < 0 && !mv[s][w]) inv = w;
      e.way = (inv >= 0) ? inv : mrr[s];
    end
    e.tag_known = mw[s][e.way];
    e.tag       = mt[s][e.way];
    return e;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
    end
    flush_left = 0;
  endtask

  // One clock cycle: apply inputs, check per-cycle status, advance model.
  task automatic drive(input bit lv, input int li, input int lt,
                       input bit fv, input int fi, input int fw, input int ft,
                       input bit fr);
    bit idle;
    lk_valid = lv;   lk_index = IDX_W'(li);   lk_tag = TAG_W'(lt);
    fill_valid = fv; fill_index = IDX_W'(fi); fill_way = WAY_W'(fw); fill_tag = TAG_W'(ft);
    flush_req = fr;
    check("busy", 32'(busy), 32'(flush_left > 0));
    check("flush_done", 32'(flush_done), 32'(flush_left == 1));
    idle = (flush_left == 0);
    if (lv && idle) sbq.push_back(model_lookup(li, lt));
    if (idle) begin
      if (fr) begin
        flush_left = SETS;
        flush_pos  = 0;
      end else if (fv) begin
        mv[fi][fw] = 1; mw[fi][fw] = 1; mt[fi][fw] = ft;
        mrr[fi] = (fw + 1) % WAYS;
      end
    end else begin
      for (int w = 0; w < WAYS; w++) mv[flush_pos][w] = 0;
      flush_pos++;
      flush_left--;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    lk_valid = 0; fill_valid = 0; flush_req = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_hit", 32'(rsp_hit), 0);
    check("rst_rsp_way", 32'(rsp_way), 0);
    check("rst_rsp_tag", 32'(rsp_tag), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_flush_done", 32'(flush_done), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0 && cyc > sbq[0].cyc + 1) begin
      e = sbq.pop_front();
      check("rsp_missing", 0, 1);
    end
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 0);
      end else begin
        e = sbq.pop_front();
        check("rsp_latency", 32'(cyc), 32'(e.cyc + 1));
        check("rsp_hit", 32'(rsp_hit), 32'(e.hit));
        check("rsp_way", 32'(rsp_way), 32'(e.way));
        if (e.tag_known) check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin mw[s][w] = 0; mt[s][w] = 0; end
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // basic fill then hit
    drive(0, 0, 0, 1, 5, 2, 'hABCDE, 0);
    drive(1, 5, 'hABCDE, 0, 0, 0, 0, 0);
    idle_cycle();

    // victim selection in set 9
    drive(0, 0, 0, 1, 9, 0, 'h00900, 0);
    drive(0, 0, 0, 1, 9, 1, 'h00901, 0);
    drive(1, 9, 'h0FFFF, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 9, 2, 'h00902, 0);
    drive(0, 0, 0, 1, 9, 3, 'h00903, 0);
    drive(1, 9, 'h0FFFF, 0, 0, 0, 0, 0);
    idle_cycle();

    // same-cycle fill and lookup, then repeat
    drive(1, 3, 'h11111, 1, 3, 0, 'h11111, 0);
    drive(1, 3, 'h11111, 0, 0, 0, 0, 0);
    idle_cycle();

    // full flush with lookups and fills attempted while busy
    drive(0, 0, 0, 1, 10, 0, 'h0AAAA, 0);
    drive(0, 0, 0, 1, 11, 1, 'h0BBBB, 0);
    drive(0, 0, 0, 1, 12, 3, 'h0CCCC, 0);
    drive(0, 0, 0, 1, 12, 0, 'h0DDDD, 1);   // fill dropped, flush starts
    for (int i = 0; i < SETS; i++) drive(1, 10, 'h0AAAA, 1, 13, 0, 'h0EEEE, 1);
    idle_cycle();
    drive(1, 10, 'h0AAAA, 0, 0, 0, 0, 0);
    drive(1, 11, 'h0BBBB, 0, 0, 0, 0, 0);
    drive(1, 12, 'h0CCCC, 0, 0, 0, 0, 0);
    drive(1, 5,  'hABCDE, 0, 0, 0, 0, 0);
    idle_cycle();

    // reset in the middle of a flush
    drive(0, 0, 0, 1, 20, 1, 'h02020, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) idle_cycle();
    do_reset();
    for (int i = 0; i < 3; i++) idle_cycle();
    drive(1, 20, 'h02020, 0, 0, 0, 0, 0);
    drive(1, 9, 'h00900, 0, 0, 0, 0, 0);
    idle_cycle();

`ifdef TAG_BANK_PARITY_EN
    drive(0, 0, 0, 1, 1, 1, 'h12345, 0);
    idle_cycle();
    dut.tag_q[1][1] = dut.tag_q[1][1] ^ 20'h00001;
    mt[1][1] = 'h12344;
    drive(1, 1, 'h12345, 0, 0, 0, 0, 0);
    check("rsp_perr", 32'(rsp_perr), 1);
    idle_cycle();
`endif

    // randomized traffic over a small set/tag space so hits are frequent
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 7), 'h100 + $urandom_range(0, 5),
            $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, WAYS - 1),
            'h100 + $urandom_range(0, 5), $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 3; i++) idle_cycle();
    while (sbq.size() > 0) begin
      void'(sbq.pop_front());
      check("rsp_never_seen", 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
